fetch_pc_ctrl: RTL and testbench
================================

FETCH_PC_CTRL -- requirements
Module: fetch_pc_ctrl

Interface
REQ-001 Parameter: WIDTH, 32, address/data width.
REQ-002 Parameter: RESET_PC, 32'h00000060, first fetch address after reset.
REQ-003 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: trap_valid  in  1  trap redirect request, sampled every cycle.
REQ-006 Port: trap_target  in  WIDTH  trap handler address.
REQ-007 Port: redirect_valid  in  1  taken branch/jump request, sampled every cycle.
REQ-008 Port: redirect_target  in  WIDTH  branch/jump target.
REQ-009 Port: id_stall  in  1  decode cannot accept the presented instruction.
REQ-010 Port: imem_read  out  1  instruction memory read request.
REQ-011 Port: imem_address  out  WIDTH  read address; equals pc.
REQ-012 Port: imem_resp  in  1  read complete; imem_rdata valid this cycle.
REQ-013 Port: imem_rdata  in  WIDTH  fetched instruction.
REQ-014 Port: if_valid  out  1  if_instr/if_pc valid for decode.
REQ-015 Port: if_pc  out  WIDTH  address of if_instr.
REQ-016 Port: if_instr  out  WIDTH  fetched instruction.
REQ-017 Port: pc  out  WIDTH  current fetch PC.

Function
REQ-018 FSM states: IDLE, FETCH, HOLD; IDLE -> FETCH unconditionally on first clock after reset release.
REQ-019 FETCH: imem_read=1, imem_address=pc held stable until imem_resp.
REQ-020 FETCH, imem_resp=1, no pending or same-cycle redirect: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4, -> HOLD.
REQ-021 HOLD: imem_read=0; if_valid=1 and outputs stable while id_stall=1; id_stall=0 consumes instruction -> FETCH next cycle with if_valid=0.
REQ-022 Redirect priority: trap_valid over redirect_valid in the same cycle; effective target has bits[1:0] forced to 0.
REQ-023 Redirect in IDLE or HOLD: pc<=target, if_valid<=0 (presented instruction killed even if id_stall=0), -> FETCH.
REQ-024 Redirect in FETCH without imem_resp: address not changed; target latched in pend_valid/pend_target; outstanding response discarded on arrival, then pc<=pend_target, pend_valid<=0, stay FETCH.
REQ-025 Redirect in FETCH coincident with imem_resp: response discarded, pc<=target, stay FETCH, if_valid stays 0.
REQ-026 Multiple redirects during one outstanding read: latest wins, except a pending trap is not overwritten by a later non-trap redirect.
REQ-027 Redirect coincident with pending target at response: same-cycle request wins (subject to REQ-026).
REQ-028 pc+4 computed modulo 2^WIDTH; 32'hFFFFFFFC wraps to 32'h00000000.
REQ-029 Throughput: one instruction per 2 cycles minimum (FETCH 1 cycle with immediate resp, HOLD 1 cycle).

Reset
REQ-030 rst_n=0 asynchronously forces: state=IDLE, pc=RESET_PC, imem_read=0, if_valid=0, if_pc=0, if_instr=0, pend_valid=0, pend_target=0.
REQ-031 Reset mid-read: outstanding request abandoned; any imem_resp in IDLE ignored.

Structure
REQ-032 Package fetch_pkg holds fetch_state_t enum (IDLE, FETCH, HOLD) and RESET_PC default constant.
REQ-033 One sub-module fetch_pc_reg: WIDTH-bit load-enabled register, async active-low reset to RESET_PC.

Verification
REQ-034 Reset release, imem_resp same cycle as read, id_stall=0 -> addresses 0x60, 0x64, 0x68, if_valid every 2nd cycle.
REQ-035 id_stall=1 for 5 cycles in HOLD -> if_instr/if_pc unchanged, imem_read=0 throughout, next address pc+4 after release.
REQ-036 redirect_valid target 0x200 issued 1 cycle into a 3-cycle read -> address stays until resp, response dropped, next read at 0x200.
REQ-037 trap_valid (0x100) and redirect_valid (0x300) same cycle, then redirect 0x400 during same read -> next fetch 0x100.
REQ-038 pc=0xFFFFFFFC fetched -> next address 0x00000000; redirect target 0x207 -> fetch at 0x204.
REQ-039 rst_n asserted mid-FETCH, late imem_resp -> ignored, first fetch after release at 0x60.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_pkg : shared fetch-stage types and constants
// Rev 1.0
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0060;
  localparam int unsigned INSTR_BYTES    = 4;

endpackage
`default_nettype wire

// File: rtl/fetch_pc_reg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_pc_reg : load-enabled PC register, async active-low reset to RESET_PC
// Rev 1.0
// -----------------------------------------------------------------------------
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RESET_PC;
    end else if (load_en) begin
      value_q <= d;
    end
  end

  assign q = value_q;

endmodule
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// fetch_pc_ctrl : fetch PC sequencer with trap/branch redirect and decode hold
// Rev 1.0
// -----------------------------------------------------------------------------
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_target,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             id_stall,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  input  logic             imem_resp,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             if_valid,
  output logic [WIDTH-1:0] if_pc,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] pc
);

  fetch_state_t     state_q, state_d;
  logic             imem_read_q, imem_read_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [WIDTH-1:0] if_instr_q, if_instr_d;
  logic             pend_valid_q, pend_valid_d;
  logic             pend_trap_q, pend_trap_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  logic             pc_load;
  logic [WIDTH-1:0] pc_next;

  logic             req_valid;
  logic [WIDTH-1:0] req_target;
  logic             req_takes_pend;
  logic             merged_valid;
  logic             merged_trap;
  logic [WIDTH-1:0] merged_target;

  fetch_pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_en (pc_load),
    .d       (pc_next),
    .q       (pc)
  );

  always_comb begin
    req_valid  = trap_valid | redirect_valid;
    req_target = (trap_valid ? trap_target : redirect_target) & ~WIDTH'(3);
    // A parked trap is never displaced by a later plain branch/jump.
    req_takes_pend = req_valid && !(pend_valid_q && pend_trap_q && !trap_valid);
    merged_valid   = pend_valid_q | req_valid;
    merged_target  = req_takes_pend ? req_target : pend_target_q;
    merged_trap    = req_takes_pend ? trap_valid : pend_trap_q;
  end

  always_comb begin
    state_d       = state_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    pc_load       = 1'b0;
    pc_next       = pc;

    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (req_valid) begin
          pc_load = 1'b1;
          pc_next = req_target;
        end
      end

      FETCH: begin
        pend_valid_d  = merged_valid;
        pend_trap_d   = merged_trap;
        pend_target_d = merged_target;
        if (imem_resp) begin
          pc_load = 1'b1;
          if (merged_valid) begin
            // Response belongs to the old path: drop it and restart at the target.
            pc_next      = merged_target;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
          end else begin
            if_instr_d = imem_rdata;
            if_pc_d    = pc;
            if_valid_d = 1'b1;
            pc_next    = pc + WIDTH'(INSTR_BYTES);
            state_d    = HOLD;
          end
        end
      end

      HOLD: begin
        if (req_valid) begin
          pc_load    = 1'b1;
          pc_next    = req_target;
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end else if (!id_stall) begin
          if_valid_d = 1'b0;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d    = IDLE;
        if_valid_d = 1'b0;
      end
    endcase

    imem_read_d = (state_d == FETCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      imem_read_q   <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      imem_read_q   <= imem_read_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign imem_read    = imem_read_q;
  assign imem_address = pc;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_fetch_pc_ctrl : scoreboard bench for fetch_pc_ctrl with a behavioural model
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] pc;

  fetch_pc_ctrl #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0060)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .imem_read       (imem_read),
    .imem_address    (imem_address),
    .imem_resp       (imem_resp),
    .imem_rdata      (imem_rdata),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .pc              (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } deliv_t;

  deliv_t exp_q[$];

  // Reference model: the fetch address stream and which fetched words reach decode.
  typedef enum int {M_IDLE, M_READ, M_SHOW} mphase_t;
  mphase_t     m_phase;
  logic [31:0] m_addr;
  bit          m_redir;
  bit          m_redir_trap;
  logic [31:0] m_redir_tgt;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_addr  = 32'h0000_0060;
    m_redir = 1'b0;
    m_redir_trap = 1'b0;
    m_redir_tgt  = 32'h0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit          req;
    logic [31:0] tgt;
    deliv_t      d;
    req = trap_valid || redirect_valid;
    tgt = (trap_valid ? trap_target : redirect_target) & 32'hFFFF_FFFC;
    case (m_phase)
      M_IDLE: begin
        if (req) m_addr = tgt;
        m_phase = M_READ;
      end
      M_READ: begin
        if (req && !(m_redir && m_redir_trap && !trap_valid)) begin
          m_redir_tgt  = tgt;
          m_redir_trap = trap_valid;
        end
        if (req) m_redir = 1'b1;
        if (imem_resp) begin
          if (m_redir) begin
            m_addr  = m_redir_tgt;
            m_redir = 1'b0;
            m_redir_trap = 1'b0;
          end else begin
            d.pc    = m_addr;
            d.instr = mem_word(m_addr);
            exp_q.push_back(d);
            m_addr  = m_addr + 32'd4;
            m_phase = M_SHOW;
          end
        end
      end
      default: begin
        if (req) begin
          m_addr  = tgt;
          m_phase = M_READ;
        end else if (!id_stall) begin
          m_phase = M_READ;
        end
      end
    endcase
  endtask

  // Advance one clock: the model consumes the inputs the DUT just sampled, then new inputs go out.
  task automatic drive(input bit t, input logic [31:0] tt, input bit r, input logic [31:0] rt,
                       input bit st, input bit rsp);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    trap_valid      = t;
    trap_target     = tt;
    redirect_valid  = r;
    redirect_target = rt;
    id_stall        = st;
    imem_resp       = rsp;
    imem_rdata      = rsp ? mem_word(imem_address) : $urandom;
  endtask

  task automatic reset_checks();
    chk("rst_pc", pc, 32'h0000_0060);
    chk("rst_imem_read", 32'(imem_read), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
  endtask

  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    reset_checks();
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every cycle and pops the scoreboard when a new instruction is presented.
  deliv_t      mon_d;
  logic [31:0] cur_pc;
  logic [31:0] cur_instr;
  bit          prev_v = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      chk("imem_read", 32'(imem_read), 32'(m_phase == M_READ));
      chk("pc", pc, m_addr);
      if (m_phase == M_READ) chk("imem_address", imem_address, m_addr);
      chk("if_valid", 32'(if_valid), 32'(m_phase == M_SHOW));
      if (if_valid && !prev_v) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL delivery: actual if_pc=%08h presented, required none", if_pc);
        end else begin
          mon_d     = exp_q.pop_front();
          cur_pc    = mon_d.pc;
          cur_instr = mon_d.instr;
          chk("if_pc", if_pc, cur_pc);
          chk("if_instr", if_instr, cur_instr);
        end
      end else if (if_valid) begin
        chk("if_pc_hold", if_pc, cur_pc);
        chk("if_instr_hold", if_instr, cur_instr);
      end
      prev_v = if_valid;
    end
  end

  initial begin
    bit          t, r, st, rsp;
    logic [31:0] tt, rt;
    model_reset();
    trap_valid = 0; trap_target = 0; redirect_valid = 0; redirect_target = 0;
    id_stall = 0; imem_resp = 0; imem_rdata = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) drive(0, 0, 0, 0, 0, 0);
    reset_checks();
    rst_n = 1'b1;

    // Back-to-back fetches with immediate response: 0x60, 0x64, 0x68.
    repeat (6) drive(0, 0, 0, 0, 0, 1);
    // Decode stall held in HOLD.
    repeat (7) drive(0, 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0, 0);
    // Redirect during a 3-cycle read.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h200, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    // Trap beats redirect, later plain redirect does not displace the trap.
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 32'h100, 1, 32'h300, 0, 0);
    drive(0, 0, 1, 32'h400, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 1);
    // Wrap at the top of the address space, then a misaligned target.
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h207, 0, 1);
    repeat (4) drive(0, 0, 0, 0, 0, 1);
    // Reset in the middle of an outstanding read, with late responses.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    mid_reset();
    repeat (4) drive(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 2000; i++) begin
      t   = ($urandom_range(0, 15) == 0);
      r   = ($urandom_range(0, 7) == 0);
      tt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
      rt  = $urandom;
      st  = ($urandom_range(0, 2) == 0);
      rsp = (m_phase == M_READ) && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 299) == 0) mid_reset();
      else drive(t, tt, r, rt, st, rsp);
    end

    repeat (4) drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
